// File: rtl/ace_controller.sv
// ACE master-side controller: turns cache fill, writeback and upgrade requests
// into single-beat ACE transactions and returns a one-cycle completion pulse.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a request; request fields latched on accept
// S_AR_SEND | AR channel valid (ReadShared or CleanUnique) until arready
// S_R_WAIT  | rready high, waiting for the single read data beat
// S_WR_SEND | AW and W valid, each dropped after its own handshake
// S_B_WAIT  | bready high, waiting for the write response
// S_DONE    | ace_ready plus rack or wack for one cycle
module ace_controller #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  read_req,
  input  logic                  write_req,
  input  logic                  invalid_req,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  ace_ready,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  fill_shared,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [3:0]            arsnoop,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [3:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awsnoop,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic                  rack,
  output logic                  wack
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AR_SEND = 3'd1,
    S_R_WAIT  = 3'd2,
    S_WR_SEND = 3'd3,
    S_B_WAIT  = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [3:0] SNOOP_READ_SHARED  = 4'b0001;
  localparam logic [3:0] SNOOP_CLEAN_UNIQUE = 4'b1011;
  localparam logic [2:0] SNOOP_WRITE_BACK   = 3'b011;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [3:0]            snoop_q;
  logic                  is_write_q;
  logic                  is_read_q;
  logic                  aw_pend_q;
  logic                  w_pend_q;
  logic [DATA_WIDTH-1:0] fill_data_q;
  logic                  fill_shared_q;
  logic                  resp_err_q;

  logic any_req;
  logic accept;
  logic aw_last;
  logic w_last;

  // Only PassDirty-free single-beat responses matter here; remaining bits are ignored.
  logic unused_resp_bits;
  assign unused_resp_bits = ^{rresp[2], rresp[0], bresp[0]};

  assign any_req = write_req | invalid_req | read_req;
  assign accept  = (state_q == S_IDLE) && any_req;
  // A channel counts as finished once it is already done or handshakes this cycle.
  assign aw_last = !aw_pend_q || awready;
  assign w_last  = !w_pend_q || wready;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; request priority is write, then invalid, then read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (write_req)                   state_d = S_WR_SEND;
        else if (invalid_req || read_req) state_d = S_AR_SEND;
      end
      S_AR_SEND: if (arready)           state_d = S_R_WAIT;
      S_R_WAIT:  if (rvalid)            state_d = S_DONE;
      S_WR_SEND: if (aw_last && w_last) state_d = S_B_WAIT;
      S_B_WAIT:  if (bvalid)            state_d = S_DONE;
      S_DONE:                           state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  // Channel and handshake outputs decoded from the state and registered fields.
  always_comb begin
    arvalid     = (state_q == S_AR_SEND);
    rready      = (state_q == S_R_WAIT);
    bready      = (state_q == S_B_WAIT);
    ace_ready   = (state_q == S_DONE);
    rack        = (state_q == S_DONE) && !is_write_q;
    wack        = (state_q == S_DONE) && is_write_q;
    awvalid     = aw_pend_q;
    wvalid      = w_pend_q;
    awsnoop     = aw_pend_q ? SNOOP_WRITE_BACK : 3'b000;
    araddr      = addr_q;
    awaddr      = addr_q;
    wdata       = data_q;
    arsnoop     = snoop_q;
    fill_data   = fill_data_q;
    fill_shared = fill_shared_q;
    resp_err    = resp_err_q;
  end

  // Request latch, write-channel pending flags and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q        <= '0;
      data_q        <= '0;
      snoop_q       <= 4'b0000;
      is_write_q    <= 1'b0;
      is_read_q     <= 1'b0;
      aw_pend_q     <= 1'b0;
      w_pend_q      <= 1'b0;
      fill_data_q   <= '0;
      fill_shared_q <= 1'b0;
      resp_err_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr;
        data_q     <= wb_data;
        is_write_q <= write_req;
        is_read_q  <= !write_req && !invalid_req;
        snoop_q    <= write_req   ? 4'b0000 :
                      invalid_req ? SNOOP_CLEAN_UNIQUE : SNOOP_READ_SHARED;
        aw_pend_q  <= write_req;
        w_pend_q   <= write_req;
        resp_err_q <= 1'b0;
      end
      if (state_q == S_WR_SEND) begin
        if (awready) aw_pend_q <= 1'b0;
        if (wready)  w_pend_q  <= 1'b0;
      end
      if (state_q == S_R_WAIT && rvalid) begin
        resp_err_q <= rresp[1];
        // An upgrade carries no line data, so the last fill stays visible.
        if (is_read_q) begin
          fill_data_q   <= rdata;
          fill_shared_q <= rresp[3];
        end
      end
      if (state_q == S_B_WAIT && bvalid) resp_err_q <= bresp[1];
    end
  end

endmodule

// File: tb/tb_ace_controller.sv
// Bench for ace_controller: the bench plays both the cache controller and the
// ACE slave; a transaction-level model predicts every output on each cycle.
module tb_ace_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        read_req = 1'b0, write_req = 1'b0, invalid_req = 1'b0;
  logic [31:0] req_addr = '0, wb_data = '0;
  logic        ace_ready;
  logic [31:0] fill_data;
  logic        fill_shared, resp_err;
  logic [31:0] araddr;
  logic [3:0]  arsnoop;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = '0;
  logic [3:0]  rresp = '0;
  logic        rvalid = 1'b0;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsnoop;
  logic        awvalid;
  logic        awready = 1'b0;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready = 1'b0;
  logic [1:0]  bresp = '0;
  logic        bvalid = 1'b0;
  logic        bready;
  logic        rack, wack;

  ace_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .read_req(read_req), .write_req(write_req), .invalid_req(invalid_req),
    .req_addr(req_addr), .wb_data(wb_data),
    .ace_ready(ace_ready), .fill_data(fill_data), .fill_shared(fill_shared), .resp_err(resp_err),
    .araddr(araddr), .arsnoop(arsnoop), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsnoop(awsnoop), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rack(rack), .wack(wack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one outstanding transaction and the phases it has passed.
  bit          m_valid = 0, busy = 0, fresh = 0, is_wr = 0, is_inv = 0;
  bit          ar_done = 0, r_done = 0, aw_done = 0, w_done = 0, b_done = 0;
  bit          just_reset = 0;
  logic [31:0] m_addr = '0, m_data = '0, m_fill = '0;
  bit          m_shared = 0, m_err = 0;
  int          ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  // Slave behaviour knobs set by the stimulus process.
  bit          rand_delays = 0, force_resp = 0, zero_lat_chk = 0;
  int          cfg_ar = 0, cfg_r = 0, cfg_aw = 0, cfg_w = 0, cfg_b = 0;
  logic [31:0] f_rdata = '0;
  logic [3:0]  f_rresp = '0;
  logic [1:0]  f_bresp = '0;
  int          cyc = 0, acc_cyc = 0;
  int          n_ready = 0, n_rack = 0, n_wack = 0;
  logic [3:0]  last_arsnoop = '0;
  logic [2:0]  last_awsnoop = '0;

  function automatic int pick(input int cfg);
    return rand_delays ? int'($urandom_range(0, 3)) : cfg;
  endfunction

  // Compare outputs to the model, then act as slave for the coming edge.
  always @(negedge clk) begin
    bit done_now;
    cyc++;
    if (reset) begin
      busy = 0; fresh = 0; m_fill = '0; m_shared = 0; m_err = 0;
      just_reset = 1; m_valid = 1;
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    end else if (m_valid) begin
      if (just_reset) begin
        chk("reset_ctrl", 64'({arvalid, awvalid, wvalid, rready, bready, ace_ready, rack, wack}), 64'(0));
        chk("reset_regs", 64'({fill_shared, resp_err, arsnoop, awsnoop}), 64'(0));
        chk("reset_fill_data", 64'(fill_data), 64'(0));
        chk("reset_addr", 64'({araddr, awaddr}), 64'(0));
        chk("reset_wdata", 64'(wdata), 64'(0));
        just_reset = 0;
      end
      done_now = busy && (is_wr ? b_done : r_done);
      chk("ace_ready", 64'(ace_ready), 64'(done_now));
      chk("rack", 64'(rack), 64'(done_now && !is_wr));
      chk("wack", 64'(wack), 64'(done_now && is_wr));
      chk("arvalid", 64'(arvalid), 64'(busy && !is_wr && !ar_done));
      chk("rready", 64'(rready), 64'(busy && !is_wr && ar_done && !r_done));
      chk("awvalid", 64'(awvalid), 64'(busy && is_wr && !aw_done));
      chk("wvalid", 64'(wvalid), 64'(busy && is_wr && !w_done));
      chk("bready", 64'(bready), 64'(busy && is_wr && aw_done && w_done && !b_done));
      chk("awsnoop", 64'(awsnoop), awvalid ? 64'(3'b011) : 64'(0));
      if (arvalid) begin
        chk("araddr", 64'(araddr), 64'(m_addr));
        chk("arsnoop", 64'(arsnoop), is_inv ? 64'(4'b1011) : 64'(4'b0001));
        last_arsnoop = arsnoop;
      end
      if (awvalid) begin
        chk("awaddr", 64'(awaddr), 64'(m_addr));
        last_awsnoop = awsnoop;
      end
      if (wvalid) chk("wdata", 64'(wdata), 64'(m_data));
      chk("fill_data", 64'(fill_data), 64'(m_fill));
      chk("fill_shared", 64'(fill_shared), 64'(m_shared));
      chk("resp_err", 64'(resp_err), 64'(m_err));
      if (ace_ready) n_ready++;
      if (rack) n_rack++;
      if (wack) n_wack++;
      if (done_now && zero_lat_chk) chk("min_latency", 64'(cyc - acc_cyc), 64'(3));

      fresh = 0;
      if (!busy && (write_req || invalid_req || read_req)) begin
        busy = 1; fresh = 1;
        is_wr = write_req; is_inv = !write_req && invalid_req;
        m_addr = req_addr; m_data = wb_data; m_err = 0;
        ar_done = 0; r_done = 0; aw_done = 0; w_done = 0; b_done = 0;
        ar_cnt = pick(cfg_ar); r_cnt = pick(cfg_r);
        aw_cnt = pick(cfg_aw); w_cnt = pick(cfg_w); b_cnt = pick(cfg_b);
        acc_cyc = cyc;
      end else if (done_now) begin
        busy = 0;
      end

      arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
      rdata = 32'($urandom); rresp = 4'($urandom); bresp = 2'($urandom);
      if (busy && !fresh) begin
        if (is_wr) begin
          if (aw_done && w_done && !b_done) begin
            if (b_cnt > 0) b_cnt--;
            else begin
              bvalid = 1; b_done = 1;
              if (force_resp) bresp = f_bresp;
              m_err = bresp[1];
            end
          end
          if (!aw_done) begin
            if (aw_cnt > 0) aw_cnt--; else begin awready = 1; aw_done = 1; end
          end
          if (!w_done) begin
            if (w_cnt > 0) w_cnt--; else begin wready = 1; w_done = 1; end
          end
        end else begin
          if (ar_done && !r_done) begin
            if (r_cnt > 0) r_cnt--;
            else begin
              rvalid = 1; r_done = 1;
              if (force_resp) begin rdata = f_rdata; rresp = f_rresp; end
              m_err = rresp[1];
              if (!is_inv) begin m_fill = rdata; m_shared = rresp[3]; end
            end
          end
          if (!ar_done) begin
            if (ar_cnt > 0) ar_cnt--; else begin arready = 1; ar_done = 1; end
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    do begin
      @(posedge clk); #1; t++;
    end while (!ace_ready && t < 400);
    if (!ace_ready) begin
      checks++; failures++;
      $display("FAIL txn_timeout: got no ace_ready after %0d cycles, expected a completion", t);
    end
  endtask

  task automatic set_req(input bit wr, input bit inv, input bit rd,
                         input logic [31:0] a, input logic [31:0] d);
    write_req = wr; invalid_req = inv; read_req = rd; req_addr = a; wb_data = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int n0;
    idle(3);
    reset = 0;
    idle(2);

    // Fill: ReadShared, zero-wait slave, shared clean line.
    zero_lat_chk = 1; force_resp = 1; f_rdata = 32'hDEADBEEF; f_rresp = 4'b1000;
    n0 = n_ready;
    set_req(0, 0, 1, 32'h40, 32'h0);
    wait_ready();
    chk("fill_rack", 64'(rack), 64'(1));
    chk("fill_snoop", 64'(last_arsnoop), 64'(4'b0001));
    chk("fill_data_lit", 64'(fill_data), 64'(32'hDEADBEEF));
    chk("fill_shared_lit", 64'(fill_shared), 64'(1));
    set_req(0, 0, 0, 32'h0, 32'h0);
    idle(3);
    chk("fill_one_pulse", 64'(n_ready - n0), 64'(1));

    // Writeback with AW accepted one cycle before W.
    zero_lat_chk = 0; cfg_w = 1; f_bresp = 2'b00;
    set_req(1, 0, 0, 32'h80, 32'h12345678);
    wait_ready();
    chk("wb_wack", 64'(wack), 64'(1));
    chk("wb_awsnoop", 64'(last_awsnoop), 64'(3'b011));
    chk("wb_resp_err", 64'(resp_err), 64'(0));
    set_req(0, 0, 0, 32'h0, 32'h0);
    cfg_w = 0;
    idle(2);

    // Write and read together: writeback first, then the fill.
    zero_lat_chk = 1; f_rdata = 32'hCAFEF00D; f_rresp = 4'b0000;
    n0 = n_wack;
    set_req(1, 0, 1, 32'hC0, 32'hA5A5A5A5);
    wait_ready();
    chk("both_first_wack", 64'(wack), 64'(1));
    write_req = 0;
    wait_ready();
    chk("both_second_rack", 64'(rack), 64'(1));
    chk("both_snoop", 64'(last_arsnoop), 64'(4'b0001));
    chk("both_fill", 64'(fill_data), 64'(32'hCAFEF00D));
    chk("both_one_write", 64'(n_wack - n0), 64'(1));
    set_req(0, 0, 0, 32'h0, 32'h0);
    idle(2);

    // Upgrade with SLVERR: error flagged, fill data untouched.
    f_rdata = 32'h55555555; f_rresp = 4'b0010;
    set_req(0, 1, 0, 32'h100, 32'h0);
    wait_ready();
    chk("inv_snoop", 64'(last_arsnoop), 64'(4'b1011));
    chk("inv_resp_err", 64'(resp_err), 64'(1));
    chk("inv_fill_kept", 64'(fill_data), 64'(32'hCAFEF00D));
    set_req(0, 0, 0, 32'h0, 32'h0);
    idle(2);

    // AR stalled, then reset while waiting.
    zero_lat_chk = 0; cfg_ar = 100;
    n0 = n_ready;
    set_req(0, 0, 1, 32'h1C0, 32'h0);
    idle(7);
    chk("stall_arvalid", 64'(arvalid), 64'(1));
    chk("stall_araddr", 64'(araddr), 64'(32'h1C0));
    reset = 1;
    set_req(0, 0, 0, 32'h0, 32'h0);
    idle(1);
    reset = 0;
    chk("stall_reset_arvalid", 64'(arvalid), 64'(0));
    idle(10);
    chk("stall_no_ready", 64'(n_ready - n0), 64'(0));
    cfg_ar = 0;

    // Randomised traffic with random slave delays and responses.
    force_resp = 0; rand_delays = 1;
    for (int i = 0; i < 60; i++) begin
      logic [2:0] kind;
      kind = 3'($urandom_range(1, 7));
      set_req(kind[2], kind[1], kind[0], 32'($urandom), 32'($urandom));
      wait_ready();
      set_req(0, 0, 0, 32'($urandom), 32'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish by %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
